// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the state enum.
package uart_pkg;

  localparam int unsigned UART_CLK_DIV_DEF = 5000;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_param_if.sv
// Request/holding-register handshake between a producer and uart_tx_param.
interface uart_tx_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              en_data_in;
  logic              tx_ready;

  modport master (output data_in, output en_data_in, input tx_ready);
  modport slave  (input data_in, input en_data_in, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..CLK_DIV-1 and wraps; bit_end is high on the
// last cycle of each bit, clear holds the counter at zero.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next_c
);
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  assign bit_end_next_c = (cnt_d == LAST);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q   <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_end <= bit_end_next_c;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-word holding register.
// Define UART_TX_PARITY_EN to honour PARITY (adds the parity bit and state).
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = UART_CLK_DIV_DEF,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned PARITY    = PAR_NONE
) (
  input  logic           clk,
  input  logic           res,
  uart_tx_param_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           TX
);
  localparam int unsigned IDX_W = 3;

  if (CLK_DIV < 2 || CLK_DIV > 8191 || DATA_W < 5 || DATA_W > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY > PAR_ODD) begin : g_bad_cfg
    $error("uart_tx_param: unsupported parameter set");
  end

  uart_state_e       state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_empty_q, hold_empty_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, unload;
  logic              bit_end, bit_end_next_c;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON  = (PARITY != PAR_NONE);
  localparam bit PAR_INV = (PARITY == PAR_ODD);
  logic par_q, par_d;
`endif

  // Counter is held at zero while idle so every frame starts on a fresh bit.
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk            (clk),
    .res            (res),
    .clear          (state_q == ST_IDLE),
    .bit_end        (bit_end),
    .bit_end_next_c (bit_end_next_c)
  );

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    unload       = 1'b0;
    accept       = bus.en_data_in & hold_empty_q;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!hold_empty_q) begin
          unload  = 1'b1;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            if (PAR_ON) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
          tx_d      = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
            // A held word starts straight after the last stop bit.
            if (!hold_empty_q) begin
              unload  = 1'b1;
              state_d = ST_START;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (unload) begin
      shreg_d      = hold_q;
      hold_empty_d = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d        = (^hold_q) ^ PAR_INV;
`endif
    end
    // Accept after unload so a same-edge refill keeps the register full.
    if (accept) begin
      hold_d       = bus.data_in;
      hold_empty_d = 1'b0;
    end

    done_d = (state_d == ST_STOP) && (bit_idx_d == IDX_W'(STOP_BITS - 1)) &&
             bit_end_next_c;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res) par_q <= 1'b0;
    else      par_q <= par_d;
  end
`endif

  assign bus.tx_ready = hold_empty_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign TX           = tx_q;

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_DIV, default 5000, clock cycles per bit (24 MHz / 4800 baud); legal range 2..8191.
REQ-002 Parameter DATA_W, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1, 2.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 clk  input  1  system clock; one clock domain.
REQ-006 res  input  1  reset, asynchronous, active-low.
REQ-007 data_in  input  DATA_W  byte to transmit, sampled on acceptance.
REQ-008 en_data_in  input  1  request; accepted on a clk edge where en_data_in=1 and tx_ready=1.
REQ-009 tx_ready  output  1  1 = holding register empty, request can be accepted.
REQ-010 busy  output  1  1 = frame on the line (any state other than IDLE).
REQ-011 done  output  1  one-cycle pulse on the last cycle of each frame's final stop bit.
REQ-012 TX  output  1  serial line, idle high, LSB first.

Function
REQ-013 Frame SHALL be: start (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-014 Every bit SHALL last exactly CLK_DIV cycles, counted by a bit counter that runs 0..CLK_DIV-1 and wraps.
REQ-015 States: IDLE, START, DATA, PARITY, STOP; IDLE->START on pending word; START->DATA after one bit; DATA->PARITY (parity on) or STOP after DATA_W bits; PARITY->STOP after one bit; STOP->START (pending word) or IDLE after STOP_BITS bits.
REQ-016 The block SHALL contain a one-word holding register; tx_ready=1 while it is empty.
REQ-017 Accepted request in IDLE: TX SHALL go low on the clk edge following acceptance (latency 1 cycle).
REQ-018 Request accepted mid-frame SHALL be held, and its start bit SHALL follow the previous frame's last stop bit with zero idle cycles.
REQ-019 en_data_in while tx_ready=0 SHALL be ignored; held word and current frame unaffected.
REQ-020 Acceptance and holding-register unload on the same edge SHALL be legal: the new word is stored and tx_ready stays 0.
REQ-021 Parity bit: XOR of the DATA_W data bits for even; its inverse for odd.
REQ-022 Data bits above DATA_W are not used; no width truncation warnings permitted on data_in.

Reset
REQ-023 On res low, asynchronously: TX=1, busy=0, tx_ready=1, done=0, state=IDLE, bit counter=0, holding register empty.
REQ-024 Reset mid-frame SHALL abort the frame and discard any held word; TX returns high immediately.
REQ-025 First acceptance after res release SHALL behave as REQ-017.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY honoured, PARITY state present.
REQ-027 Macro UART_TX_PARITY_EN undefined: PARITY ignored, no parity state or logic; frames carry no parity bit.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum typedef, parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the default CLK_DIV.
REQ-029 Sub-module uart_baud_gen (parameter CLK_DIV) SHALL provide the bit counter and a one-cycle bit_end strobe, with a synchronous clear used on frame start.

Verification
REQ-030 CLK_DIV=10, DATA_W=8, PARITY=0: accept 0x53 -> TX 0,1,1,0,0,1,0,1,0,1, each 10 cycles; done pulses at cycle 100; busy=1 for 100 cycles.
REQ-031 UART_TX_PARITY_EN defined, PARITY=1, data 0x53 -> parity bit 0; PARITY=2 -> parity bit 1; frame 110 cycles.
REQ-032 Accept 0xA5, then 0x3C during frame 1 -> no idle gap between frames; tx_ready=0 from second acceptance until frame 2 start.
REQ-033 Third request while holding register full -> ignored; only 0xA5 and 0x3C appear on TX.
REQ-034 res low at cycle 45 of a frame -> TX=1, busy=0, tx_ready=1 at once; no done pulse; held word never sent.
REQ-035 DATA_W=5, STOP_BITS=2, data 0x1F -> TX 0,1,1,1,1,1,1,1; frame 80 cycles at CLK_DIV=10.
